// File: rtl/vjtag_reg_pkg.sv
// Shared constants and decode types for the vjtag_host register target.
// Register offsets are byte addresses on a 4-byte stride.
package vjtag_reg_pkg;

    localparam int unsigned REG_ID      = 32'h00;
    localparam int unsigned REG_CTRL    = 32'h04;
    localparam int unsigned REG_STATUS  = 32'h08;
    localparam int unsigned REG_SCRATCH = 32'h0C;
    localparam int unsigned REG_PEND    = 32'h10;
    localparam int unsigned REG_MASK    = 32'h14;
    localparam int unsigned REG_WR_CNT  = 32'h18;
    localparam int unsigned REG_ERR     = 32'h1C;

    localparam logic [31:0] UNMAPPED_DATA = 32'hDEADDEAD;
    localparam logic [31:0] DEFAULT_ID    = 32'h0000A5C3;

    typedef enum logic [3:0] {
        SEL_ID,
        SEL_CTRL,
        SEL_STATUS,
        SEL_SCRATCH,
        SEL_PEND,
        SEL_MASK,
        SEL_WR_CNT,
        SEL_ERR,
        SEL_NONE
    } reg_sel_e;

endpackage

// File: rtl/vjtag_rd_pipe.sv
// RD_LAT-deep read-response pipe: captured data walks one stage per cycle
// and the last stage drives rrvalid/rdata. Flush drops everything in flight.
module vjtag_rd_pipe #(
    parameter int unsigned DW     = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          rrvalid,
    output logic [DW-1:0] rdata,
    output logic          done
);

    logic [RD_LAT-1:0] vld_q;
    logic [DW-1:0]     dat_q [RD_LAT];

    // Data stages only load behind a valid so the last stage holds its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid & ~flush;
            if (in_valid && !flush) begin
                dat_q[0] <= in_data;
            end
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1] & ~flush;
                if (vld_q[i-1] && !flush) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign rrvalid = vld_q[RD_LAT-1];
    assign rdata   = dat_q[RD_LAT-1];
    assign done    = vld_q[RD_LAT-1];

endmodule

// File: rtl/vjtag_reg_target.sv
// Register-bank responder for the vjtag_host bus: CTRL/SCRATCH storage,
// status sampling, sticky interrupt pending bits and access counters.
module vjtag_reg_target
    import vjtag_reg_pkg::*;
#(
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 16,
    parameter int unsigned RD_LAT   = 1,
    parameter logic [31:0] ID_VALUE = DEFAULT_ID
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          soft_rst_n,
    input  logic [AW-1:0] address,
    input  logic          wvalid,
    input  logic [DW-1:0] wdata,
    output logic          wready,
    input  logic          rvalid,
    output logic          rready,
    output logic          rrvalid,
    output logic [DW-1:0] rdata,
    output logic [DW-1:0] ctrl_out,
    input  logic [DW-1:0] status_in,
    input  logic [DW-1:0] event_in,
    output logic          irq
);

    logic [DW-1:0] ctrl_q, scratch_q, pend_q, mask_q, wr_cnt_q, err_cnt_q, status_q;
    logic          irq_q, busy_q, rd_done;
    reg_sel_e      sel;
    logic [DW-1:0] rd_val, pend_clr, err_next;
    logic [DW:0]   err_sum;
    logic [1:0]    err_inc;
    logic          wr_acc, rd_acc, unmapped;

    // Exact full-width compare: misaligned or out-of-map addresses fall to SEL_NONE.
    always_comb begin
        sel = SEL_NONE;
        case (address)
            AW'(REG_ID):      sel = SEL_ID;
            AW'(REG_CTRL):    sel = SEL_CTRL;
            AW'(REG_STATUS):  sel = SEL_STATUS;
            AW'(REG_SCRATCH): sel = SEL_SCRATCH;
            AW'(REG_PEND):    sel = SEL_PEND;
            AW'(REG_MASK):    sel = SEL_MASK;
            AW'(REG_WR_CNT):  sel = SEL_WR_CNT;
            AW'(REG_ERR):     sel = SEL_ERR;
            default:          sel = SEL_NONE;
        endcase
    end

    always_comb begin
        rd_val = DW'(UNMAPPED_DATA);
        case (sel)
            SEL_ID:      rd_val = DW'(ID_VALUE);
            SEL_CTRL:    rd_val = ctrl_q;
            SEL_STATUS:  rd_val = status_q;
            SEL_SCRATCH: rd_val = scratch_q;
            SEL_PEND:    rd_val = pend_q;
            SEL_MASK:    rd_val = mask_q;
            SEL_WR_CNT:  rd_val = wr_cnt_q;
            SEL_ERR:     rd_val = err_cnt_q;
            default:     rd_val = DW'(UNMAPPED_DATA);
        endcase
    end

    assign unmapped = (sel == SEL_NONE);
    assign wr_acc   = wvalid & soft_rst_n;
    assign rd_acc   = rvalid & ~busy_q & soft_rst_n;
    assign err_inc  = 2'(wr_acc & unmapped) + 2'(rd_acc & unmapped);
    assign err_sum  = {1'b0, err_cnt_q} + (DW+1)'(err_inc);
    assign err_next = err_sum[DW] ? '1 : err_sum[DW-1:0];
    assign pend_clr = (wr_acc && sel == SEL_PEND) ? wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            scratch_q <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
            irq_q     <= 1'b0;
        end else if (!soft_rst_n) begin
            ctrl_q    <= '0;
            scratch_q <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (wr_acc) begin
                case (sel)
                    SEL_CTRL:    ctrl_q    <= wdata;
                    SEL_SCRATCH: scratch_q <= wdata;
                    SEL_MASK:    mask_q    <= wdata;
                    default:     ;
                endcase
            end
            // New events win over a same-cycle W1C clear.
            pend_q    <= (pend_q & ~pend_clr) | event_in;
            wr_cnt_q  <= wr_cnt_q + DW'(wr_acc);
            err_cnt_q <= (wr_acc && sel == SEL_ERR) ? '0 : err_next;
            irq_q     <= |(pend_q & mask_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
        end else begin
            status_q <= status_in;
        end
    end

    // Busy covers acceptance through the rrvalid cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
        end else if (!soft_rst_n) begin
            busy_q <= 1'b0;
        end else if (rd_acc) begin
            busy_q <= 1'b1;
        end else if (rd_done) begin
            busy_q <= 1'b0;
        end
    end

    vjtag_rd_pipe #(
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (~soft_rst_n),
        .in_valid (rd_acc),
        .in_data  (rd_val),
        .rrvalid  (rrvalid),
        .rdata    (rdata),
        .done     (rd_done)
    );

    assign wready   = 1'b1;
    assign rready   = ~busy_q;
    assign ctrl_out = ctrl_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_vjtag_reg_target.sv
// Drives three targets (RD_LAT 1..3) with shared stimulus and compares every
// cycle against a register-map level model.
module tb_vjtag_reg_target;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n, soft_rst_n, wvalid, rvalid;
    logic [15:0] address, wdata, status_in, event_in;

    logic        wready_a  [NI];
    logic        rready_a  [NI];
    logic        rrvalid_a [NI];
    logic        irq_a     [NI];
    logic [15:0] rdata_a   [NI];
    logic [15:0] ctrl_a    [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        vjtag_reg_target #(
            .AW     (16),
            .DW     (16),
            .RD_LAT (g + 1)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .soft_rst_n (soft_rst_n),
            .address    (address),
            .wvalid     (wvalid),
            .wdata      (wdata),
            .wready     (wready_a[g]),
            .rvalid     (rvalid),
            .rready     (rready_a[g]),
            .rrvalid    (rrvalid_a[g]),
            .rdata      (rdata_a[g]),
            .ctrl_out   (ctrl_a[g]),
            .status_in  (status_in),
            .event_in   (event_in),
            .irq        (irq_a[g])
        );
    end

    // Reference model state
    logic [15:0] m_ctrl, m_scr, m_pend, m_mask, m_wrc, m_errc, m_stat, exp_rd;
    logic        m_irq;
    bit          act     [NI];
    int          due     [NI];
    logic [15:0] last_rd [NI];
    int          cyc;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit m_mapped(input logic [15:0] a);
        return (a[1:0] == 2'b00) && (a < 16'h0020);
    endfunction

    function automatic logic [15:0] m_read(input logic [15:0] a);
        if (!m_mapped(a)) return 16'hDEAD;
        case (a)
            16'h0000: return 16'hA5C3;
            16'h0004: return m_ctrl;
            16'h0008: return m_stat;
            16'h000C: return m_scr;
            16'h0010: return m_pend;
            16'h0014: return m_mask;
            16'h0018: return m_wrc;
            default:  return m_errc;
        endcase
    endfunction

    function automatic bit all_idle();
        for (int i = 0; i < NI; i++) begin
            if (act[i] && cyc <= due[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic m_reset();
        m_ctrl = '0; m_scr = '0; m_pend = '0; m_mask = '0;
        m_wrc = '0; m_errc = '0; m_stat = '0; m_irq = 1'b0; exp_rd = '0;
        for (int i = 0; i < NI; i++) begin
            act[i] = 1'b0; due[i] = 0; last_rd[i] = '0;
        end
    endtask

    // One accepting clock edge of the register map
    task automatic m_edge();
        logic [15:0] clr;
        int          inc;
        bit          unm;
        logic        nirq;
        cyc++;
        unm = !m_mapped(address);
        if (!soft_rst_n) begin
            m_ctrl = '0; m_scr = '0; m_pend = '0; m_mask = '0;
            m_wrc = '0; m_errc = '0; m_irq = 1'b0;
            for (int i = 0; i < NI; i++) act[i] = 1'b0;
        end else begin
            nirq = |(m_pend & m_mask);
            inc  = 0;
            clr  = '0;
            if (rvalid) begin
                exp_rd = m_read(address);
                for (int i = 0; i < NI; i++) begin
                    act[i] = 1'b1; due[i] = cyc + i;
                end
                if (unm) inc++;
            end
            if (wvalid) begin
                m_wrc = m_wrc + 16'd1;
                if (unm) inc++;
                if (address == 16'h0004) m_ctrl = wdata;
                if (address == 16'h000C) m_scr  = wdata;
                if (address == 16'h0014) m_mask = wdata;
                if (address == 16'h0010) clr    = wdata;
            end
            if (wvalid && address == 16'h001C) m_errc = '0;
            else if (int'(m_errc) + inc > 65535) m_errc = 16'hFFFF;
            else m_errc = 16'(int'(m_errc) + inc);
            m_pend = (m_pend & ~clr) | event_in;
            m_irq  = nirq;
        end
        m_stat = status_in;
        for (int i = 0; i < NI; i++) begin
            if (act[i] && cyc == due[i]) last_rd[i] = exp_rd;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rrvalid[%0d]", i), 32'(rrvalid_a[i]), 32'(act[i] && cyc == due[i]));
            chk($sformatf("rready[%0d]", i),  32'(rready_a[i]),  32'(!(act[i] && cyc <= due[i])));
            chk($sformatf("rdata[%0d]", i),   32'(rdata_a[i]),   32'(last_rd[i]));
            chk($sformatf("ctrl_out[%0d]", i), 32'(ctrl_a[i]),   32'(m_ctrl));
            chk($sformatf("irq[%0d]", i),     32'(irq_a[i]),     32'(m_irq));
            chk($sformatf("wready[%0d]", i),  32'(wready_a[i]),  32'd1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_edge();
        #1;
        check_all();
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 10 && !all_idle(); k++) tick();
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        address = a; wdata = d; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        wait_idle();
        address = a; rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        wait_idle();
        tick();
    endtask

    logic [15:0] tbl [10];

    initial begin
        tbl = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010,
                16'h0014, 16'h0018, 16'h001C, 16'h0020, 16'h0006};
        cyc = 0;
        rst_n = 1'b0; soft_rst_n = 1'b1; wvalid = 1'b0; rvalid = 1'b0;
        address = '0; wdata = '0; status_in = '0; event_in = '0;
        m_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ID read and CTRL write/read-back
        rd(16'h0000);
        chk("id_read", 32'(rdata_a[0]), 32'h0000A5C3);
        wr(16'h0004, 16'h00FF);
        chk("ctrl_after_wr", 32'(ctrl_a[0]), 32'h000000FF);
        rd(16'h0004);
        chk("ctrl_read", 32'(rdata_a[0]), 32'h000000FF);
        rd(16'h0018);
        chk("wr_cnt_1", 32'(rdata_a[1]), 32'd1);

        // Same-cycle read and write of SCRATCH returns the old value
        address = 16'h000C; wdata = 16'h1234; wvalid = 1'b1; rvalid = 1'b1;
        tick();
        wvalid = 1'b0; rvalid = 1'b0;
        wait_idle();
        chk("scratch_pre", 32'(rdata_a[2]), 32'h0);
        rd(16'h000C);
        chk("scratch_post", 32'(rdata_a[2]), 32'h1234);

        // Interrupt pending / mask, set beats clear
        event_in = 16'h0005; tick(); event_in = '0;
        wr(16'h0014, 16'h0004);
        tick(); tick();
        chk("irq_set", 32'(irq_a[0]), 32'd1);
        address = 16'h0010; wdata = 16'h0004; wvalid = 1'b1; event_in = 16'h0004;
        tick();
        wvalid = 1'b0; event_in = '0;
        rd(16'h0010);
        chk("pend_set_wins", 32'(rdata_a[0]), 32'h5);
        wr(16'h0010, 16'h0004);
        tick(); tick();
        rd(16'h0010);
        chk("pend_cleared", 32'(rdata_a[0]), 32'h1);
        chk("irq_clear", 32'(irq_a[0]), 32'd0);

        // Unmapped accesses
        rd(16'h0020);
        chk("unmapped_0x20", 32'(rdata_a[0]), 32'hDEAD);
        rd(16'h0006);
        chk("unmapped_0x06", 32'(rdata_a[1]), 32'hDEAD);
        wr(16'h0040, 16'hBEEF);
        rd(16'h001C);
        chk("err_cnt_3", 32'(rdata_a[0]), 32'd3);
        wr(16'h001C, 16'h5555);
        rd(16'h001C);
        chk("err_cleared", 32'(rdata_a[0]), 32'd0);

        // Soft reset aborts an in-flight read
        address = 16'h0000; rvalid = 1'b1;
        tick();
        rvalid = 1'b0; soft_rst_n = 1'b0;
        tick();
        soft_rst_n = 1'b1;
        tick(); tick(); tick();
        rd(16'h0004);
        chk("ctrl_soft", 32'(rdata_a[1]), 32'd0);
        rd(16'h000C);
        chk("scratch_soft", 32'(rdata_a[1]), 32'd0);
        rd(16'h0018);
        chk("wr_cnt_soft", 32'(rdata_a[1]), 32'd0);
        rd(16'h0000);
        chk("id_soft", 32'(rdata_a[2]), 32'h0000A5C3);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int pick;
            soft_rst_n = ($urandom % 40) != 0;
            pick       = int'($urandom_range(0, 10));
            address    = (pick == 10) ? 16'($urandom) : tbl[pick];
            wvalid     = ($urandom % 2) == 0;
            wdata      = 16'($urandom);
            rvalid     = all_idle() && (($urandom % 3) == 0);
            event_in   = (($urandom % 4) == 0) ? 16'($urandom) : 16'h0;
            status_in  = 16'($urandom);
            tick();
        end
        wvalid = 1'b0; rvalid = 1'b0; event_in = '0; soft_rst_n = 1'b1;
        wait_idle();
        tick();

        // Async reset in the middle of a read
        address = 16'h0008; rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all();
        tick(); tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick(); tick();
        rd(16'h0000);
        chk("id_after_rst", 32'(rdata_a[2]), 32'h0000A5C3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
